// File: rtl/conv_output_buffer_pkg.sv
// conv_output_buffer_pkg: shared defaults and read-FSM encodings for the conv output buffer
package conv_output_buffer_pkg;
  localparam int OB_DATA_WIDTH = 32;
  localparam int OB_FEATURE_NUM = 4;
  localparam int OB_FEATURE_ROWS = 6;
  localparam int OB_FEATURE_COLS = 6;
  typedef enum logic {STATE_OB_IDLE = 1'b0, STATE_OB_DRAIN = 1'b1} ob_state_t;
endpackage

// File: rtl/conv_output_bank.sv
// conv_output_bank: one feature-map bank, row-wide write port and pixel-wide combinational read
module conv_output_bank
  import conv_output_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = OB_DATA_WIDTH,
  parameter int FEATURE_NUM = OB_FEATURE_NUM,
  parameter int FEATURE_ROWS = OB_FEATURE_ROWS,
  parameter int FEATURE_COLS = OB_FEATURE_COLS
) (
  input  logic                               clk,
  input  logic                               we,
  input  logic [1:0]                         wr_feature,
  input  logic [2:0]                         wr_row,
  input  logic [FEATURE_COLS*DATA_WIDTH-1:0] wr_data,
  input  logic [1:0]                         rd_feature,
  input  logic [2:0]                         rd_row,
  input  logic [2:0]                         rd_col,
  output logic [DATA_WIDTH-1:0]              rd_data
);
  localparam int DEPTH = FEATURE_NUM * FEATURE_ROWS;
  localparam int AW = $clog2(DEPTH);
  logic [FEATURE_COLS*DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wa, ra;
  assign wa = AW'(wr_feature * FEATURE_ROWS + wr_row);
  assign ra = AW'(rd_feature * FEATURE_ROWS + rd_row);
  assign rd_data = mem[ra][rd_col*DATA_WIDTH +: DATA_WIDTH];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wr_data;
endmodule

// File: rtl/conv_output_buffer.sv
// conv_output_buffer: ping-pong feature-map buffer draining one pixel per handshake.
// Define CONV_OUTPUT_RELU_EN to zero negative pixels on the output path.
module conv_output_buffer
  import conv_output_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = OB_DATA_WIDTH,
  parameter int FEATURE_NUM = OB_FEATURE_NUM,
  parameter int FEATURE_ROWS = OB_FEATURE_ROWS,
  parameter int FEATURE_COLS = OB_FEATURE_COLS
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               kernel_calc_fin,
  input  logic                               image_calc_fin,
  input  logic [1:0]                         feature_idx,
  input  logic [2:0]                         feature_row,
  input  logic [FEATURE_COLS*DATA_WIDTH-1:0] row_data,
  input  logic                               out_ready,
  output logic                               out_valid,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic [1:0]                         out_feature,
  output logic [2:0]                         out_row,
  output logic [2:0]                         out_col,
  output logic                               out_last,
  output logic                               buf_full,
  output logic                               overflow
);
  ob_state_t state, state_next;
  logic wr_bank, rd_bank, wr_ok, fire, done, col_end, row_end, feat_end;
  logic [1:0] bank_full, f;
  logic [2:0] r, c;
  logic [DATA_WIDTH-1:0] pix [2];
  logic [DATA_WIDTH-1:0] sel;
  assign wr_ok = kernel_calc_fin && !bank_full[wr_bank];
  assign col_end = c == 3'(FEATURE_COLS - 1);
  assign row_end = r == 3'(FEATURE_ROWS - 1);
  assign feat_end = f == 2'(FEATURE_NUM - 1);
  assign out_valid = state == STATE_OB_DRAIN;
  assign out_last = out_valid && feat_end && row_end && col_end;
  assign fire = out_valid && out_ready;
  assign done = fire && out_last;
  assign buf_full = &bank_full;
  assign out_feature = f;
  assign out_row = r;
  assign out_col = c;
  assign sel = rd_bank ? pix[1] : pix[0];
  genvar b;
  generate
    for (b = 0; b < 2; b++) begin : g_bank
      conv_output_bank #(
        .DATA_WIDTH(DATA_WIDTH), .FEATURE_NUM(FEATURE_NUM),
        .FEATURE_ROWS(FEATURE_ROWS), .FEATURE_COLS(FEATURE_COLS)
      ) u_bank (
        .clk(clk), .we(wr_ok && wr_bank == 1'(b)), .wr_feature(feature_idx),
        .wr_row(feature_row), .wr_data(row_data), .rd_feature(f), .rd_row(r),
        .rd_col(c), .rd_data(pix[b])
      );
    end
  endgenerate
  // Output is gated by out_valid so reset and IDLE present zero regardless of storage
`ifdef CONV_OUTPUT_RELU_EN
  assign out_data = out_valid && !sel[DATA_WIDTH-1] ? sel : '0;
`else
  assign out_data = out_valid ? sel : '0;
`endif
  always_comb
    state_next = state == STATE_OB_IDLE ? (bank_full[rd_bank] ? STATE_OB_DRAIN : STATE_OB_IDLE)
                                        : (done ? STATE_OB_IDLE : STATE_OB_DRAIN);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= STATE_OB_IDLE;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      bank_full <= '0;
      overflow <= 1'b0;
      f <= '0;
      r <= '0;
      c <= '0;
    end else begin
      state <= state_next;
      if (kernel_calc_fin && bank_full[wr_bank]) overflow <= 1'b1;
      // Reader clear and writer set always target different banks, so both land
      if (done) begin
        bank_full[rd_bank] <= 1'b0;
        rd_bank <= ~rd_bank;
      end
      if (wr_ok && image_calc_fin) begin
        bank_full[wr_bank] <= 1'b1;
        wr_bank <= ~wr_bank;
      end
      if (fire) begin
        c <= col_end ? '0 : c + 3'd1;
        r <= col_end ? (row_end ? '0 : r + 3'd1) : r;
        f <= col_end && row_end ? (feat_end ? '0 : f + 2'd1) : f;
      end
    end
endmodule

// File: tb/tb_conv_output_buffer.sv
// tb_conv_output_buffer: directed checks of write, drain, backpressure, overflow, ping-pong and reset
module tb_conv_output_buffer;
  localparam int DW = 32;
  localparam int COLS = 6;
  logic clk = 1'b0, rst = 1'b1, kernel_calc_fin = 1'b0, image_calc_fin = 1'b0, out_ready = 1'b0;
  logic [1:0] feature_idx = '0;
  logic [2:0] feature_row = '0;
  logic [COLS*DW-1:0] row_data = '0;
  logic out_valid, out_last, buf_full, overflow;
  logic [DW-1:0] out_data;
  logic [1:0] out_feature;
  logic [2:0] out_row, out_col;
  int checks = 0, errors = 0;

  conv_output_buffer dut (
    .clk(clk), .rst(rst), .kernel_calc_fin(kernel_calc_fin), .image_calc_fin(image_calc_fin),
    .feature_idx(feature_idx), .feature_row(feature_row), .row_data(row_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_feature(out_feature), .out_row(out_row), .out_col(out_col),
    .out_last(out_last), .buf_full(buf_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pixv(input int base, input int f, input int r, input int c);
    return DW'(base + f * 100 + r * 10 + c);
  endfunction

  task automatic write_raw(input int f, input int r, input logic [COLS*DW-1:0] d, input bit fin);
    @(negedge clk);
    kernel_calc_fin = 1'b1;
    image_calc_fin = fin;
    feature_idx = 2'(f);
    feature_row = 3'(r);
    row_data = d;
    @(posedge clk); #1;
    kernel_calc_fin = 1'b0;
    image_calc_fin = 1'b0;
  endtask

  task automatic write_image(input int base, input int lo, input int hi);
    logic [COLS*DW-1:0] d;
    for (int k = lo; k <= hi; k++) begin
      for (int c = 0; c < COLS; c++) d[c*DW +: DW] = pixv(base, k / 6, k % 6, c);
      write_raw(k / 6, k % 6, d, k == 23);
    end
  endtask

  // With lat set, called just after the image_calc_fin edge; the toggle phase starts there with ready=1
  task automatic drain(input int base, input bit lat, input bit tog, input int stop_at, input int exp_cyc);
    int k = 0, cyc = 0, w = 0;
    bit rdy;
    logic [DW-1:0] ed;
    logic [1:0] ef;
    logic [2:0] er, ec;
    if (lat) begin
      out_ready = 1'b1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_first_edge: out_valid=%b expected 0", out_valid); end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_second_edge: out_valid=%b expected 1", out_valid); end
    end else
      while (out_valid !== 1'b1 && w < 50) begin @(posedge clk); #1; w++; end
    while (k < stop_at && cyc < 600) begin
      rdy = tog ? cyc[0] : 1'b1;
      out_ready = rdy;
      ef = 2'(k / 36); er = 3'((k / 6) % 6); ec = 3'(k % 6);
      ed = pixv(base, k / 36, (k / 6) % 6, k % 6);
      checks++;
      if ({out_valid, out_last, out_feature, out_row, out_col, out_data} !== {1'b1, k == 143, ef, er, ec, ed}) begin
        errors++;
        $display("FAIL pixel_%0d: got v=%b l=%b f=%0d r=%0d c=%0d d=%0d, expected v=1 l=%b f=%0d r=%0d c=%0d d=%0d",
                 k, out_valid, out_last, out_feature, out_row, out_col, out_data, k == 143, ef, er, ec, ed);
      end
      @(posedge clk); #1;
      if (rdy) k++;
      cyc++;
    end
    out_ready = 1'b0;
    if (stop_at == 144) begin
      checks++;
      if (cyc != exp_cyc) begin errors++; $display("FAIL drain_cycles: got %0d expected %0d", cyc, exp_cyc); end
      checks++;
      if ({out_valid, out_last} !== 2'b00) begin errors++; $display("FAIL drain_idle: valid/last=%b expected 00", {out_valid, out_last}); end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_last, buf_full, overflow, out_feature, out_row, out_col, out_data} !== '0) begin
      errors++; $display("FAIL reset_outputs: v=%b l=%b full=%b ovf=%b d=%h expected all 0", out_valid, out_last, buf_full, overflow, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, buf_full, overflow} !== 3'b000) begin errors++; $display("FAIL post_reset_idle: v/full/ovf=%b expected 000", {out_valid, buf_full, overflow}); end
  endtask

  task automatic test_stream;
    write_image(0, 0, 23);
    drain(0, 1'b1, 1'b0, 144, 144);
  endtask

  task automatic test_toggle;
    write_image(0, 0, 23);
    drain(0, 1'b1, 1'b1, 144, 288);
  endtask

  task automatic test_full;
    logic [COLS*DW-1:0] d;
    write_image(1000, 0, 23);
    write_image(2000, 0, 23);
    checks++;
    if (buf_full !== 1'b1) begin errors++; $display("FAIL buf_full_set: got %b expected 1", buf_full); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_before: got %b expected 0", overflow); end
    for (int c = 0; c < COLS; c++) d[c*DW +: DW] = DW'(3000 + c);
    write_raw(0, 0, d, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b expected 1", overflow); end
    checks++;
    if ({out_valid, out_data} !== {1'b1, pixv(1000, 0, 0, 0)}) begin
      errors++; $display("FAIL hold_no_ready: v=%b d=%0d expected v=1 d=1000", out_valid, out_data);
    end
    drain(1000, 1'b0, 1'b0, 144, 144);
    drain(2000, 1'b1, 1'b0, 144, 144);
    checks++;
    if ({overflow, buf_full} !== 2'b10) begin errors++; $display("FAIL overflow_sticky: ovf/full=%b expected 10", {overflow, buf_full}); end
  endtask

  task automatic test_relu;
    logic [COLS*DW-1:0] d;
    logic [DW-1:0] exp0;
    int n = 0;
`ifdef CONV_OUTPUT_RELU_EN
    exp0 = '0;
`else
    exp0 = 32'hFFFF_FFF6;
`endif
    d = '0;
    d[DW-1:0] = 32'hFFFF_FFF6;
    d[2*DW-1:DW] = 32'd5;
    write_image(0, 0, 22);
    write_raw(0, 0, d, 1'b0);
    write_image(0, 23, 23);
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out_data} !== {1'b1, exp0}) begin errors++; $display("FAIL relu_negative: v=%b d=%h expected v=1 d=%h", out_valid, out_data, exp0); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_col, out_data} !== {3'd1, 32'd5}) begin errors++; $display("FAIL relu_positive: c=%0d d=%h expected c=1 d=5", out_col, out_data); end
    while (!(out_valid && out_last) && n < 300) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, buf_full} !== 2'b00) begin errors++; $display("FAIL relu_drain_end: v/full=%b expected 00", {out_valid, buf_full}); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    write_image(0, 0, 23);
    fork
      drain(0, 1'b1, 1'b0, 144, 144);
      begin
        int n = 0;
        write_image(700, 0, 22);
        while (!(out_valid && out_last) && n < 300) begin @(posedge clk); #1; n++; end
        write_image(700, 23, 23);
      end
    join
    checks++;
    if (dut.bank_full !== 2'b10) begin errors++; $display("FAIL b2b_bank_flags: got %b expected 10", dut.bank_full); end
    drain(700, 1'b1, 1'b0, 144, 144);
  endtask

  task automatic test_reset_mid;
    write_image(300, 0, 23);
    drain(300, 1'b1, 1'b0, 50, 0);
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_last, buf_full, overflow, out_feature, out_row, out_col, out_data} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs: v=%b l=%b f=%0d r=%0d c=%0d d=%0d expected all 0", out_valid, out_last, out_feature, out_row, out_col, out_data);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    write_image(400, 0, 23);
    drain(400, 1'b1, 1'b0, 144, 144);
  endtask

  initial begin
    test_reset;
    test_stream;
    test_toggle;
    test_full;
    test_relu;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_output_buffer.md
CONV_OUTPUT_BUFFER -- requirements
Module: conv_output_buffer

Interface
REQ-001 Parameter DATA_WIDTH, 32, bit width of one feature-map pixel.
REQ-002 Parameter FEATURE_NUM, 4, feature maps per image; equals TOTAL_WEIGHT.
REQ-003 Parameter FEATURE_ROWS, 6, rows per feature map; equals TOTAL_SHIFT.
REQ-004 Parameter FEATURE_COLS, 6, pixels per row; equals the kernel array width.
REQ-005 clk  input  1  single clock; all logic is on the rising edge.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 kernel_calc_fin  input  1  row-write strobe from the conv layer controller.
REQ-008 image_calc_fin  input  1  last-row-of-image qualifier; valid only with kernel_calc_fin.
REQ-009 feature_idx  input  2  feature map index of the row being written.
REQ-010 feature_row  input  3  row index of the row being written.
REQ-011 row_data  input  FEATURE_COLS*DATA_WIDTH  kernel array results; column 0 in the LSBs.
REQ-012 out_ready  input  1  downstream accepts a pixel.
REQ-013 out_valid  output  1  out_data holds a valid pixel.
REQ-014 out_data  output  DATA_WIDTH  pixel value.
REQ-015 out_feature, out_row, out_col  output  2/3/3  coordinates of out_data.
REQ-016 out_last  output  1  out_data is the final pixel of the image.
REQ-017 buf_full  output  1  both banks are full; controller must hold off.
REQ-018 overflow  output  1  sticky flag: a row write was dropped.

Function
REQ-019 Storage SHALL be two banks (ping-pong), each holding FEATURE_NUM x FEATURE_ROWS x FEATURE_COLS pixels.
REQ-020 Write pointer and bank flags:
- wr_bank and rd_bank pointers reset to 0.
- bank_full[1:0] flags reset to 0.
REQ-021 On any edge with kernel_calc_fin=1 and bank_full[wr_bank]=0:
- row_data SHALL be written into wr_bank at (feature_idx, feature_row), all columns in one cycle.
REQ-022 If image_calc_fin=1 on that same accepted write:
- bank_full[wr_bank] SHALL be set.
- wr_bank SHALL toggle.
REQ-023 A write with bank_full[wr_bank]=1 SHALL be dropped and SHALL set overflow; overflow clears only on rst.
REQ-024 Read FSM has two states, IDLE and DRAIN; it resets to IDLE.
- IDLE -> DRAIN on the edge where bank_full[rd_bank]=1.
- DRAIN -> IDLE when the out_last pixel is accepted.
REQ-025 In DRAIN, out_valid SHALL be 1 and a pixel counter SHALL step through the bank:
- feature outermost, then row, then column.
- The counter advances only when out_valid && out_ready.
REQ-026 While out_valid=1 && out_ready=0, out_data and all coordinate outputs SHALL hold stable.
REQ-027 out_last SHALL be 1 exactly at coordinates (FEATURE_NUM-1, FEATURE_ROWS-1, FEATURE_COLS-1).
REQ-028 When the out_last pixel is accepted:
- bank_full[rd_bank] SHALL clear.
- rd_bank SHALL toggle.
- The counter SHALL return to 0.
- At least one IDLE cycle SHALL follow before the next DRAIN.
REQ-029 A bank-clear by the reader and a bank-set by the writer on the same edge (different banks) SHALL both take effect.
REQ-030 Latency: out_valid SHALL rise 2 edges after the edge that accepts the image_calc_fin write, when the reader is IDLE.
REQ-031 buf_full SHALL be combinational: bank_full[0] & bank_full[1].
REQ-032 In IDLE, out_valid and out_last SHALL be 0.

Reset
REQ-033 rst=1 SHALL asynchronously force:
- FSM to IDLE; pointers, counters, bank_full and overflow to 0.
- out_valid, out_last and buf_full to 0.
- out_data and coordinate outputs to 0.
REQ-034 Reset mid-DRAIN SHALL abandon the image.
- Storage contents need no reset.
- Post-reset behaviour SHALL be identical to power-up.

Configuration
REQ-035 With macro CONV_OUTPUT_RELU_EN defined, out_data SHALL be 0 whenever the stored pixel's MSB is 1.
REQ-036 With the macro undefined, out_data SHALL pass the stored pixel unchanged.
REQ-037 Storage contents SHALL be identical in both cases.

Structure
REQ-038 The shared package/include (alongside conv_kernel_param.v) SHALL hold:
- DATA_WIDTH, FEATURE_NUM, FEATURE_ROWS, FEATURE_COLS defaults.
- Read FSM state encodings STATE_OB_IDLE and STATE_OB_DRAIN.
REQ-039 A single sub-module, conv_output_bank, SHALL implement one bank.
- It is instantiated twice.
- It provides a row-wide write port and a pixel-wide combinational read port.

Verification
REQ-040 Write 24 rows (pixel value = idx*100 + row*10 + col), image_calc_fin on the 24th, out_ready=1:
- 144 pixels SHALL appear in order, one per cycle, starting 2 edges after the last write.
- out_last SHALL assert on value 355 only.
REQ-041 Same image with out_ready toggling 1,0,1,0:
- Each pixel SHALL be held while out_ready=0.
- The total drain SHALL take 288 cycles with no duplicates or skips.
REQ-042 Write two images with out_ready=0:
- buf_full SHALL be 1 after the second image.
- A third write SHALL be dropped and set overflow=1.
- Bank contents SHALL be unchanged.
REQ-043 Finish image B on the same edge that image A's out_last is accepted:
- Bank flags SHALL end at bank_full=2'b10.
- Image B SHALL drain after one IDLE cycle.
REQ-044 Assert rst for 1 cycle at pixel 50 of a drain:
- All outputs SHALL go to 0 immediately.
- A fresh image SHALL drain correctly from bank 0.
REQ-045 With CONV_OUTPUT_RELU_EN, write pixel 32'hFFFF_FFF6:
- The output SHALL be 0.
- Without the macro, it SHALL be FFFF_FFF6.
